sbox_scheduler: RTL and testbench
=================================

SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

Interface
REQ-001 SHALL have parameter LANES, default 4: number of S-box instances, legal values 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port st_valid, input, 1 bit: 128-bit state request present.
REQ-005 SHALL have port st_ready, output, 1 bit: state request accepted this cycle when st_valid is also high.
REQ-006 SHALL have port st_in, input, 128 bits: state to substitute.
REQ-007 SHALL have port st_out, output, 128 bits: substituted state.
REQ-008 SHALL have port st_done, output, 1 bit: one-cycle pulse when st_out is updated.
REQ-009 SHALL have port wd_valid, input, 1 bit: 32-bit key-expansion word request present.
REQ-010 SHALL have port wd_ready, output, 1 bit: word request accepted this cycle when wd_valid is also high.
REQ-011 SHALL have port wd_in, input, 32 bits: word to substitute.
REQ-012 SHALL have port wd_out, output, 32 bits: substituted word.
REQ-013 SHALL have port wd_done, output, 1 bit: one-cycle pulse when wd_out is updated.

Function
REQ-014 SHALL implement states IDLE, ST_BUSY and WD_BUSY.
REQ-015 SHALL drive st_ready and wd_ready high only in IDLE, and never both high in the same cycle.
REQ-016 SHALL arbitrate round-robin: when st_valid and wd_valid are high together, grant the requester not granted last; the last-grant flag resets to "state", so the first contested grant goes to word.
REQ-017 SHALL register the granted input on acceptance; later changes to the input port SHALL have no effect until the next acceptance.
REQ-018 SHALL move IDLE->ST_BUSY on a state grant and IDLE->WD_BUSY on a word grant.
REQ-019 SHALL in ST_BUSY substitute LANES bytes per cycle with a byte counter, MSB byte first (bits [127:120] first), taking 16/LANES cycles.
REQ-020 SHALL in WD_BUSY substitute LANES bytes per cycle, MSB byte first, taking 4/LANES cycles.
REQ-021 SHALL, when a busy state's final cycle completes, update the corresponding output, pulse its done output for exactly one cycle (registered) and return to IDLE.
REQ-022 SHALL achieve latency, from the acceptance edge to the done pulse, of 16/LANES cycles for state and 4/LANES cycles for word; with LANES=4 these are 4 and 1.
REQ-023 SHALL allow IDLE to accept a new request in the same cycle its done pulse is high (back-to-back, no bubble).
REQ-024 SHALL hold st_out and wd_out stable between done pulses and never change them mid-operation.
REQ-025 SHALL wrap the byte counter to 0 at the end of each operation; it SHALL never index beyond the last byte.
REQ-026 SHALL perform each byte substitution as the standard AES forward S-box, bit-exact.

Reset
REQ-027 SHALL, on rst high, immediately set state IDLE, counter 0, last-grant "state", st_out 0, wd_out 0, st_done 0 and wd_done 0.
REQ-028 SHALL, on reset mid-operation, discard the in-flight request and emit no done pulse for it.
REQ-029 SHALL drive ready outputs low while rst is high.

Structure
REQ-030 SHALL place the state encoding localparams and legal-LANES constants in shared package aes_pkg.
REQ-031 SHALL instantiate the existing SubTable combinational module LANES times as the only sub-module; no other S-box copy SHALL exist in the block.
REQ-032 SHALL reject an illegal LANES value at elaboration.

Verification
REQ-033 SHALL cover: LANES=4, state 00112233445566778899aabbccddeeff -> st_out 638293c31bfc33f5c4eeacea4bc12816, with st_done exactly 4 cycles after acceptance.
REQ-034 SHALL cover: word 09cf4f3c -> wd_out 018a84eb, with wd_done 1 cycle after acceptance (LANES=4) and 4 cycles after acceptance (LANES=1).
REQ-035 SHALL cover: st_valid and wd_valid held high together from reset -> grant order word, state, word, state; the ready outputs are never both high.
REQ-036 SHALL cover: rst asserted 2 cycles into a state operation -> all outputs 0, no st_done, and the next request completes correctly.
REQ-037 SHALL cover: a back-to-back request presented in the done cycle -> accepted that cycle, and the previous output is held until the new done pulse.
REQ-038 SHALL cover: exhaustive word bytes 00..ff over 64 word requests -> every byte matches the AES S-box (00->63, ff->16).

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared state encodings, lane constants and helpers for the AES
// S-box scheduling blocks.
package aes_pkg;

  localparam logic [1:0] SCHED_IDLE    = 2'd0;
  localparam logic [1:0] SCHED_ST_BUSY = 2'd1;
  localparam logic [1:0] SCHED_WD_BUSY = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = SCHED_IDLE,
    ST_BUSY = SCHED_ST_BUSY,
    WD_BUSY = SCHED_WD_BUSY
  } sched_state_e;

  localparam int LANES_ONE  = 1;
  localparam int LANES_TWO  = 2;
  localparam int LANES_FOUR = 4;

  localparam int STATE_BYTES = 16;
  localparam int WORD_BYTES  = 4;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == LANES_ONE) || (lanes == LANES_TWO) || (lanes == LANES_FOUR);
  endfunction

endpackage

// File: rtl/sbox_scheduler_sub_table.sv
// SubTable: combinational AES forward S-box, one byte in, one byte out.
// The table is a packed constant with entry 0x00 in the top byte.
module SubTable
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset 8*(255-x), i.e. the inverted index times 8.
  logic [10:0] bit_lo;

  assign bit_lo   = {~in_byte, 3'b000};
  assign out_byte = SBOX[bit_lo +: 8];

endmodule

// File: rtl/sbox_scheduler.sv
// sbox_scheduler: shares LANES AES S-box lookups between a 128-bit state
// request and a 32-bit key-expansion word request, round-robin arbitrated.
module sbox_scheduler
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         wd_valid,
  output logic         wd_ready,
  input  logic [31:0]  wd_in,
  output logic [31:0]  wd_out,
  output logic         wd_done
);

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("sbox_scheduler: LANES must be 1, 2 or 4");
  end

  localparam logic [3:0] STEP    = 4'(LANES);
  localparam logic [3:0] LAST_ST = 4'(STATE_BYTES - LANES);
  localparam logic [3:0] LAST_WD = 4'(WORD_BYTES - LANES);

  sched_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         last_st_q, last_st_d;
  logic [127:0] work_q, work_d;
  logic [127:0] st_out_q, st_out_d;
  logic [31:0]  wd_out_q, wd_out_d;
  logic         st_done_q, st_done_d;
  logic         wd_done_q, wd_done_d;

  logic         st_grant, wd_grant;
  logic [127:0] work_sub;
  logic [7:0]   sub_in  [LANES];
  logic [7:0]   sub_out [LANES];
  logic [6:0]   lane_lo [LANES];

  // Byte index 0 is the MSB byte; words ride in the top 32 bits of work_q
  // so both request kinds share the same MSB-first byte walk.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0] byte_idx;

    assign byte_idx   = cnt_q + 4'(l);
    assign lane_lo[l] = {~byte_idx, 3'b000};
    assign sub_in[l]  = work_q[lane_lo[l] +: 8];

    SubTable u_sub (
      .in_byte  (sub_in[l]),
      .out_byte (sub_out[l])
    );
  end

  always_comb begin
    work_sub = work_q;
    for (int l = 0; l < LANES; l++) begin
      work_sub[lane_lo[l] +: 8] = sub_out[l];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_st_d = last_st_q;
    work_d    = work_q;
    st_out_d  = st_out_q;
    wd_out_d  = wd_out_q;
    st_done_d = 1'b0;
    wd_done_d = 1'b0;
    st_grant  = 1'b0;
    wd_grant  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On contention the requester that did not win last time gets it.
        if (!rst) begin
          st_grant = st_valid && (!wd_valid || !last_st_q);
          wd_grant = wd_valid && (!st_valid || last_st_q);
        end
        if (st_grant) begin
          state_d   = ST_BUSY;
          cnt_d     = '0;
          last_st_d = 1'b1;
          work_d    = st_in;
        end else if (wd_grant) begin
          state_d   = WD_BUSY;
          cnt_d     = '0;
          last_st_d = 1'b0;
          work_d    = {wd_in, 96'd0};
        end
      end

      ST_BUSY: begin
        work_d = work_sub;
        cnt_d  = cnt_q + STEP;
        if (cnt_q == LAST_ST) begin
          cnt_d     = '0;
          st_out_d  = work_sub;
          st_done_d = 1'b1;
          state_d   = IDLE;
        end
      end

      WD_BUSY: begin
        work_d = work_sub;
        cnt_d  = cnt_q + STEP;
        if (cnt_q == LAST_WD) begin
          cnt_d     = '0;
          wd_out_d  = work_sub[127:96];
          wd_done_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_st_q <= 1'b1;
      work_q    <= '0;
      st_out_q  <= '0;
      wd_out_q  <= '0;
      st_done_q <= 1'b0;
      wd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_st_q <= last_st_d;
      work_q    <= work_d;
      st_out_q  <= st_out_d;
      wd_out_q  <= wd_out_d;
      st_done_q <= st_done_d;
      wd_done_q <= wd_done_d;
    end
  end

  assign st_ready = st_grant;
  assign wd_ready = wd_grant;
  assign st_out   = st_out_q;
  assign wd_out   = wd_out_q;
  assign st_done  = st_done_q;
  assign wd_done  = wd_done_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb_sbox_scheduler: self-checking bench for sbox_scheduler at LANES=4 and
// LANES=1, against a GF(2^8)-arithmetic S-box model.
module tb_sbox_scheduler;

  logic         clk;
  logic         rst;
  logic [127:0] st_in;
  logic [31:0]  wd_in;

  logic         st_valid, st_ready, st_done;
  logic [127:0] st_out;
  logic         wd_valid, wd_ready, wd_done;
  logic [31:0]  wd_out;

  logic         l1_st_valid, l1_st_ready, l1_st_done;
  logic [127:0] l1_st_out;
  logic         l1_wd_valid, l1_wd_ready, l1_wd_done;
  logic [31:0]  l1_wd_out;

  int checks = 0;
  int errors = 0;

  sbox_scheduler #(.LANES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_in    (st_in),
    .st_out   (st_out),
    .st_done  (st_done),
    .wd_valid (wd_valid),
    .wd_ready (wd_ready),
    .wd_in    (wd_in),
    .wd_out   (wd_out),
    .wd_done  (wd_done)
  );

  sbox_scheduler #(.LANES(1)) dut_l1 (
    .clk      (clk),
    .rst      (rst),
    .st_valid (l1_st_valid),
    .st_ready (l1_st_ready),
    .st_in    (st_in),
    .st_out   (l1_st_out),
    .st_done  (l1_st_done),
    .wd_valid (l1_wd_valid),
    .wd_ready (l1_wd_ready),
    .wd_in    (wd_in),
    .wd_out   (l1_wd_out),
    .wd_done  (l1_wd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: S-box as multiplicative inverse in GF(2^8) followed by
  // the affine transform.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sboxRef(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gfMul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] subState(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sboxRef(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sboxRef(w[8*i +: 8]);
    return r;
  endfunction

  function automatic logic readyOf(input bit l1, input bit is_word);
    if (l1) return is_word ? l1_wd_ready : l1_st_ready;
    return is_word ? wd_ready : st_ready;
  endfunction

  function automatic logic doneOf(input bit l1, input bit is_word);
    if (l1) return is_word ? l1_wd_done : l1_st_done;
    return is_word ? wd_done : st_done;
  endfunction

  function automatic logic [127:0] outOf(input bit l1, input bit is_word);
    if (l1) return is_word ? {96'd0, l1_wd_out} : l1_st_out;
    return is_word ? {96'd0, wd_out} : st_out;
  endfunction

  task automatic setValid(input bit l1, input bit is_word, input bit v);
    if (l1) begin
      if (is_word) l1_wd_valid = v; else l1_st_valid = v;
    end else begin
      if (is_word) wd_valid = v; else st_valid = v;
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One request: handshake, scramble the input port after acceptance, count
  // cycles to done, require the old output to hold until then.
  task automatic applyStimulus(input bit l1, input bit is_word, input logic [127:0] din,
                               input logic [127:0] exp_out, input int exp_lat,
                               input string tag);
    int waitc;
    int lat;
    bit held;
    logic [127:0] prev_out;
    if (is_word) wd_in = din[31:0]; else st_in = din;
    setValid(l1, is_word, 1'b1);
    #1;
    waitc = 0;
    while (!readyOf(l1, is_word) && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    checkOutput($sformatf("%s accept", tag), 128'(readyOf(l1, is_word)), 128'd1);
    prev_out = outOf(l1, is_word);
    @(posedge clk); #1;
    setValid(l1, is_word, 1'b0);
    st_in = {$urandom, $urandom, $urandom, $urandom};
    wd_in = $urandom;
    lat = 0;
    held = 1'b1;
    do begin
      if (outOf(l1, is_word) !== prev_out) held = 1'b0;
      @(posedge clk); #1; lat++;
    end while (!doneOf(l1, is_word) && lat < 40);
    checkOutput($sformatf("%s latency", tag), 128'(lat), 128'(exp_lat));
    checkOutput($sformatf("%s hold", tag), 128'(held), 128'd1);
    checkOutput($sformatf("%s result", tag), outOf(l1, is_word), exp_out);
    @(posedge clk); #1;
    checkOutput($sformatf("%s pulse", tag), 128'(doneOf(l1, is_word)), 128'd0);
  endtask

  typedef struct {
    bit           l1;
    bit           is_word;
    logic [127:0] din;
    logic [127:0] exp_out;
    int           exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin : main
    bit           grants [$];
    bit           both;
    bit           seen;
    bit           held;
    bit           rl1, rw;
    int           cyc, lat, rlat;
    logic [127:0] rr_s, bb_a, bb_b, mid_a, rd, rexp;
    logic [31:0]  rr_w, w;

    vecs[0] = '{1'b0, 1'b0, 128'h00112233445566778899aabbccddeeff,
                128'h638293c31bfc33f5c4eeacea4bc12816, 4};
    vecs[1] = '{1'b0, 1'b1, 128'h09cf4f3c, 128'h018a84eb, 1};
    vecs[2] = '{1'b1, 1'b1, 128'h09cf4f3c, 128'h018a84eb, 4};
    vecs[3] = '{1'b0, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                128'hd42711aee0bf98f1b8b45de51e415230, 4};
    vecs[4] = '{1'b0, 1'b1, 128'h00000000, 128'h63636363, 1};
    vecs[5] = '{1'b0, 1'b1, 128'hffffffff, 128'h16161616, 1};
    vecs[6] = '{1'b1, 1'b0, 128'h00112233445566778899aabbccddeeff,
                128'h638293c31bfc33f5c4eeacea4bc12816, 16};
    vecs[7] = '{1'b0, 1'b0, {16{8'hff}}, {16{8'h16}}, 4};

    // Reset with both requesters already waiting, then watch the grant order.
    rr_s = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    rr_w = 32'h2b7e1516;
    rst = 1'b1;
    st_in = rr_s; wd_in = rr_w;
    st_valid = 1'b1; wd_valid = 1'b1;
    l1_st_valid = 1'b0; l1_wd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst st_ready", 128'(st_ready), 128'd0);
    checkOutput("rst wd_ready", 128'(wd_ready), 128'd0);
    checkOutput("rst st_out", st_out, 128'd0);
    checkOutput("rst wd_out", 128'(wd_out), 128'd0);
    checkOutput("rst st_done", 128'(st_done), 128'd0);
    checkOutput("rst wd_done", 128'(wd_done), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    both = 1'b0;
    while (grants.size() < 4 && cyc < 100) begin
      #1;
      if (st_ready && wd_ready) both = 1'b1;
      if (wd_ready) grants.push_back(1'b0);
      else if (st_ready) grants.push_back(1'b1);
      @(negedge clk); cyc++;
    end
    st_valid = 1'b0; wd_valid = 1'b0;
    checkOutput("rr grant count", 128'(grants.size()), 128'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr grant%0d", i),
                  (i < grants.size()) ? 128'(grants[i]) : 128'd2, 128'(i % 2));
    end
    checkOutput("rr never both ready", 128'(both), 128'd0);
    cyc = 0;
    while (!st_done && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("rr st_done", 128'(st_done), 128'd1);
    checkOutput("rr st_out", st_out, subState(rr_s));
    checkOutput("rr wd_out", 128'(wd_out), 128'(subWord(rr_w)));
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].l1, vecs[i].is_word, vecs[i].din, vecs[i].exp_out,
                    vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Reset two cycles into a state operation.
    mid_a = 128'h3243f6a8885a308d313198a2e0370734;
    st_in = mid_a;
    st_valid = 1'b1;
    #1;
    cyc = 0;
    while (!st_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("midrst accept", 128'(st_ready), 128'd1);
    @(posedge clk); #1;
    st_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    st_valid = 1'b1; wd_valid = 1'b1;
    #1;
    checkOutput("midrst st_out", st_out, 128'd0);
    checkOutput("midrst wd_out", 128'(wd_out), 128'd0);
    checkOutput("midrst st_done", 128'(st_done), 128'd0);
    checkOutput("midrst wd_done", 128'(wd_done), 128'd0);
    checkOutput("midrst st_ready", 128'(st_ready), 128'd0);
    checkOutput("midrst wd_ready", 128'(wd_ready), 128'd0);
    st_valid = 1'b0; wd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (st_done) seen = 1'b1;
    end
    checkOutput("midrst no done", 128'(seen), 128'd0);
    applyStimulus(1'b0, 1'b0, mid_a, subState(mid_a), 4, "midrst redo");

    // Back-to-back: next request presented in the done cycle.
    bb_a = {$urandom, $urandom, $urandom, $urandom};
    bb_b = {$urandom, $urandom, $urandom, $urandom};
    st_in = bb_a;
    st_valid = 1'b1;
    #1;
    cyc = 0;
    while (!st_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    cyc = 0;
    while (!st_done && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("b2b first done", 128'(st_done), 128'd1);
    checkOutput("b2b first out", st_out, subState(bb_a));
    st_in = bb_b;
    st_valid = 1'b1;
    #1;
    checkOutput("b2b ready in done cycle", 128'(st_ready), 128'd1);
    @(posedge clk); #1;
    st_valid = 1'b0;
    lat = 0;
    held = 1'b1;
    do begin
      if (st_out !== subState(bb_a)) held = 1'b0;
      @(posedge clk); #1; lat++;
    end while (!st_done && lat < 40);
    checkOutput("b2b hold", 128'(held), 128'd1);
    checkOutput("b2b latency", 128'(lat), 128'd4);
    checkOutput("b2b second out", st_out, subState(bb_b));
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      applyStimulus(1'b0, 1'b1, {96'd0, w}, {96'd0, subWord(w)}, 1,
                    $sformatf("exh%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      rl1 = ($urandom_range(0, 3) == 0);
      rw  = 1'($urandom_range(0, 1));
      rd  = {$urandom, $urandom, $urandom, $urandom};
      if (rw) rd = {96'd0, rd[31:0]};
      rexp = rw ? {96'd0, subWord(rd[31:0])} : subState(rd);
      rlat = (rw ? 4 : 16) / (rl1 ? 1 : 4);
      applyStimulus(rl1, rw, rd, rexp, rlat, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
